// File: rtl/p2_sprite_renderer.sv
// Single-sprite line renderer: fetches one bitmap row per scan line from an
// external ROM into a row buffer, then emits a registered per-pixel opacity flag.
module p2_sprite_renderer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic [2:0]  action,
   input  logic [1:0]  phase,
   input  logic        mirror,
   input  logic        scale,
   output logic [9:0]  rom_addr,
   input  logic [15:0] rom_bitmap,
   output logic        pixel_on,
   output logic        busy
);

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned SPR_ROWS = 16;
   localparam int unsigned CW       = 11;
   localparam int unsigned RW       = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t         state, state_next;
   logic [9:0]     addr_next;
   logic [RW-1:0]  row_buf, row_buf_next;
   logic           busy_next;
   logic           pixel_next;

   logic [9:0]     lat_pos_x, lat_pos_y;
   logic [2:0]     lat_action;
   logic [1:0]     lat_phase;
   logic           lat_mirror, lat_scale;

   // Parameters seen by a line_start; frame_start bypasses the latch so a
   // coincident line_start already uses the new values.
   logic [9:0]     eff_pos_y;
   logic [2:0]     eff_action, san_action;
   logic [1:0]     eff_phase;
   logic           eff_scale;
   logic [CW-1:0]  eff_size, dy;
   logic           line_in;
   logic [3:0]     row;

   logic [CW-1:0]  lat_size, dx;
   logic           x_in;
   logic [3:0]     col, bit_idx;

   assign san_action = (action > 3'd4) ? 3'd0 : action;
   assign eff_pos_y  = frame_start ? pos_y      : lat_pos_y;
   assign eff_action = frame_start ? san_action : lat_action;
   assign eff_phase  = frame_start ? phase      : lat_phase;
   assign eff_scale  = frame_start ? scale      : lat_scale;

   assign eff_size = CW'(SPR_ROWS) << eff_scale;
   assign dy       = {1'b0, y} - {1'b0, eff_pos_y};
   assign line_in  = (y >= eff_pos_y) && (dy < eff_size);
   assign row      = 4'(dy >> eff_scale);

   assign lat_size = CW'(SPR_ROWS) << lat_scale;
   assign dx       = {1'b0, x} - {1'b0, lat_pos_x};
   assign x_in     = (x >= lat_pos_x) && (dx < lat_size) && ({1'b0, x} < CW'(H_ACTIVE));
   assign col      = 4'(dx >> lat_scale);
   assign bit_idx  = lat_mirror ? col : (4'd15 - col);

   // Next state, ROM address and row buffer; line_start pre-empts any fetch.
   always_comb begin
      state_next   = state;
      addr_next    = rom_addr;
      row_buf_next = row_buf;
      if (line_start) begin
         if (line_in) begin
            state_next = ISSUE;
            addr_next  = {row, eff_action, 1'b0, eff_phase};
         end else begin
            state_next   = IDLE;
            row_buf_next = 16'hFFFF;
         end
      end else begin
         case (state)
            ISSUE:   state_next = CAPTURE;
            CAPTURE: begin
               row_buf_next = rom_bitmap;
               state_next   = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
      busy_next  = (state_next != IDLE);
      pixel_next = x_in && !row_buf[bit_idx] && !busy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rom_addr <= '0;
         row_buf  <= 16'hFFFF;
         busy     <= 1'b0;
         pixel_on <= 1'b0;
      end else begin
         state    <= state_next;
         rom_addr <= addr_next;
         row_buf  <= row_buf_next;
         busy     <= busy_next;
         pixel_on <= pixel_next;
      end
   end

   // Per-frame parameter latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_pos_x  <= '0;
         lat_pos_y  <= '0;
         lat_action <= '0;
         lat_phase  <= '0;
         lat_mirror <= 1'b0;
         lat_scale  <= 1'b0;
      end else if (frame_start) begin
         lat_pos_x  <= pos_x;
         lat_pos_y  <= pos_y;
         lat_action <= san_action;
         lat_phase  <= phase;
         lat_mirror <= mirror;
         lat_scale  <= scale;
      end
   end

endmodule

// File: tb/tb_p2_sprite_renderer.sv
// Scoreboard bench for p2_sprite_renderer: a high-level sprite model predicts
// ROM addresses, busy timing and the expected pixel stream against a random ROM.
module tb_p2_sprite_renderer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start, line_start;
   logic [9:0]  x, y, pos_x, pos_y;
   logic [2:0]  action;
   logic [1:0]  phase;
   logic        mirror, scale;
   logic [9:0]  rom_addr;
   logic [15:0] rom_bitmap;
   logic        pixel_on, busy;

   p2_sprite_renderer dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
      .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y), .action(action), .phase(phase),
      .mirror(mirror), .scale(scale), .rom_addr(rom_addr), .rom_bitmap(rom_bitmap),
      .pixel_on(pixel_on), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [1024];
   always @(posedge clk) rom_bitmap <= rom[rom_addr];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: what the sprite looks like for the current line.
   int m_px, m_py, m_act, m_ph, m_mir, m_scl, m_addr;
   logic [15:0] m_row;

   bit chk = 1'b0, chk_d = 1'b0;
   bit exp_q [$];
   int x_q [$];

   always @(posedge clk) chk_d <= chk;

   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_d) begin
         if (exp_q.size() == 0) check("pixel_queue_underflow", 1, 0);
         else begin
            int xv;
            bit e;
            e  = exp_q.pop_front();
            xv = x_q.pop_front();
            check($sformatf("pixel_on x=%0d", xv), 32'(pixel_on), 32'(e));
         end
      end
   end

   function automatic bit exp_pix(int xv);
      int size, col;
      size = 16 << m_scl;
      if (xv >= 640 || xv < m_px || xv - m_px >= size) return 1'b0;
      col = (xv - m_px) / (size / 16);
      if (m_mir != 0) col = 15 - col;
      return m_row[15 - col] == 1'b0;
   endfunction

   task automatic set_params(int px, int py, int act, int ph, int mir, int scl);
      pos_x = 10'(px); pos_y = 10'(py); action = 3'(act);
      phase = 2'(ph); mirror = 1'(mir); scale = 1'(scl);
   endtask

   function automatic void model_latch();
      m_px = pos_x; m_py = pos_y; m_act = (action > 4) ? 0 : int'(action);
      m_ph = phase; m_mir = mirror; m_scl = scale;
   endfunction

   task automatic scramble_inputs();
      set_params($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 7),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
   endtask

   task automatic frame();
      frame_start = 1'b1;
      model_latch();
      @(posedge clk); #1;
      frame_start = 1'b0;
      scramble_inputs();
   endtask

   // One line: optional coincident frame_start, then the full fetch window.
   task automatic line(int yv, bit fs);
      int size, ebusy;
      y = 10'(yv);
      line_start  = 1'b1;
      frame_start = fs;
      if (fs) model_latch();
      size = 16 << m_scl;
      ebusy = (yv >= m_py && yv - m_py < size) ? 1 : 0;
      if (ebusy != 0)
         m_addr = ((yv - m_py) / (size / 16)) * 64 + m_act * 8 + m_ph;
      @(posedge clk); #1;
      line_start = 1'b0; frame_start = 1'b0;
      if (fs) scramble_inputs();
      check("busy_c1", 32'(busy), 32'(ebusy));
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      @(posedge clk); #1;
      check("busy_c2", 32'(busy), 32'(ebusy));
      check("rom_addr_hold", 32'(rom_addr), 32'(m_addr));
      @(posedge clk); #1;
      check("busy_done", 32'(busy), 0);
      m_row = (ebusy != 0) ? rom[m_addr] : 16'hFFFF;
   endtask

   task automatic sweep(int x0, int x1);
      for (int xv = x0; xv <= x1; xv++) begin
         if (xv >= 0 && xv <= 1023) begin
            x = 10'(xv);
            chk = 1'b1;
            exp_q.push_back(exp_pix(xv));
            x_q.push_back(xv);
            @(posedge clk); #1;
         end
      end
      chk = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int px, py, scl, size, yv, a1, a2;
      for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
      rom[10'o0000] = 16'hFC3F;
      rom[10'o0400] = 16'hF9DF;
      rom[10'o0043] = 16'hFF0F;
      rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0;
      x = '0; y = '0;
      set_params(0, 0, 0, 0, 0, 0);
      m_px = 0; m_py = 0; m_act = 0; m_ph = 0; m_mir = 0; m_scl = 0; m_addr = 0;
      m_row = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 0);
      check("reset_pixel", 32'(pixel_on), 0);
      check("reset_addr", 32'(rom_addr), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reference sprite, rows 0 and 4, normal and mirrored.
      set_params(100, 50, 0, 0, 0, 0); frame();
      line(50, 0); sweep(95, 120);
      line(54, 0); sweep(95, 120);
      set_params(100, 50, 0, 0, 1, 0); frame();
      line(54, 0); sweep(95, 120);
      // Pixel doubling.
      set_params(100, 50, 0, 0, 0, 1); frame();
      line(59, 0); sweep(95, 136);
      // Highest action/phase, then illegal action folding to 0.
      set_params(200, 300, 4, 3, 0, 0); frame();
      line(300, 0); sweep(200, 220);
      set_params(200, 300, 6, 3, 0, 0);
      line(303, 1); sweep(195, 220);
      // Right-edge clipping and first line below a doubled sprite.
      set_params(630, 40, 0, 0, 0, 1); frame();
      line(40, 0); sweep(620, 670); sweep(0, 21);
      line(72, 0); sweep(620, 645);

      // Abort: a second line_start during ISSUE replaces the fetch.
      set_params(10, 100, 1, 2, 0, 0); frame();
      a1 = 0 * 64 + 1 * 8 + 2;
      a2 = 7 * 64 + 1 * 8 + 2;
      rom[a1] = 16'h0000;
      rom[a2] = 16'h5AA5;
      y = 10'd100; line_start = 1'b1;
      @(posedge clk); #1;
      check("abort_first_addr", 32'(rom_addr), 32'(a1));
      m_addr = a1;
      line(107, 0); sweep(5, 30);

      // Reset during CAPTURE discards the fetch and all latched state.
      set_params(0, 0, 0, 0, 0, 0); frame();
      y = 10'd3; line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      @(posedge clk); #1;
      check("capture_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_pixel", 32'(pixel_on), 0);
      check("rst_addr", 32'(rom_addr), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      scramble_inputs();
      m_px = 0; m_py = 0; m_act = 0; m_ph = 0; m_mir = 0; m_scl = 0; m_addr = 0;
      m_row = 16'hFFFF;
      @(posedge clk); #1;
      sweep(0, 20);
      line(0, 0); sweep(0, 20);

      // Randomized frames and lines.
      for (int t = 0; t < 30; t++) begin
         px  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 620));
         py  = $urandom_range(0, 1000);
         scl = $urandom_range(0, 1);
         size = 16 << scl;
         set_params(px, py, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1), scl);
         for (int l = 0; l < 3; l++) begin
            yv = (py + int'($urandom_range(0, size + 5)) - 3) & 1023;
            if (l == 0 && $urandom_range(0, 1) == 1) line(yv, 1);
            else begin
               if (l == 0) frame();
               line(yv, 0);
            end
            sweep(px - 3, px + size + 3);
         end
      end

      check("pixel_queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/p2_sprite_renderer.md
P2_SPRITE_RENDERER -- requirements
Module: p2_sprite_renderer

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line; no pixel_on at x >= H_ACTIVE.
REQ-002 SPR_ROWS, 16, bitmap rows per sprite frame in the bitmap ROM.
REQ-003 clk  in  1  single clock domain; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 frame_start  in  1  one-cycle pulse at the start of vertical blank.
REQ-006 line_start  in  1  one-cycle pulse at least 4 cycles before the first active pixel of a line; y already holds that line.
REQ-007 x, y  in  10 each  current scan position.
REQ-008 pos_x, pos_y  in  10 each  sprite top-left corner in screen coordinates.
REQ-009 action  in  3  0 stay, 1 forward, 2 backward, 3 punch, 4 kick.
REQ-010 phase  in  2  animation phase within the action.
REQ-011 mirror, scale  in  1 each  horizontal flip; 0 = 16x16, 1 = 32x32 (2x pixel doubling).
REQ-012 rom_addr  out  10  bitmap ROM address = {row[3:0], action[2:0], 1'b0, phase[1:0]}.
REQ-013 rom_bitmap  in  16  ROM row data, valid one cycle after rom_addr; bit15 = leftmost column, 0 = opaque, 1 = transparent.
REQ-014 pixel_on  out  1  registered; sprite pixel opaque at the (x,y) of the previous cycle.
REQ-015 busy  out  1  row fetch in progress.

Function
REQ-016 On frame_start, the block SHALL latch pos_x, pos_y, action, phase, mirror and scale; action > 4 SHALL latch as 0.
REQ-017 Between frame_start pulses, the block SHALL use only latched parameters; a line_start in the same cycle as frame_start SHALL use the newly latched values.
REQ-018 Geometry: size = 16 << scale; all differences and compares SHALL use 11-bit unsigned arithmetic with no wrap.
REQ-019 A line is in-sprite iff y >= pos_y and (y - pos_y) < size.
REQ-020 Row index r SHALL be (y - pos_y) >> scale.
REQ-021 FSM states: IDLE, ISSUE, CAPTURE.
REQ-022 On line_start with an in-sprite line, the FSM SHALL go to ISSUE and drive rom_addr with row r.
REQ-023 ISSUE SHALL always go to CAPTURE on the next cycle.
REQ-024 In CAPTURE, the block SHALL load rom_bitmap into the 16-bit row buffer and return to IDLE.
REQ-025 On line_start with a line not in-sprite, the row buffer SHALL load 16'hFFFF, the FSM SHALL stay in IDLE and rom_addr SHALL stay unchanged.
REQ-026 A line_start in ISSUE or CAPTURE SHALL abort the fetch and restart in ISSUE with the new row; the aborted data SHALL never be loaded.
REQ-027 busy SHALL be 1 exactly in ISSUE and CAPTURE.
REQ-028 rom_addr SHALL stay stable from ISSUE through CAPTURE and hold its last value in IDLE.
REQ-029 Column c = (x - pos_x) >> scale; the pixel is in range iff x >= pos_x, (x - pos_x) < size and x < H_ACTIVE.
REQ-030 Bit index SHALL be 15 - c when mirror = 0 and c when mirror = 1.
REQ-031 pixel_on SHALL be registered as (in range) AND (row buffer bit == 0) AND (busy == 0), giving 1-cycle latency from x.

Reset
REQ-032 While rst_n = 0: FSM IDLE, rom_addr 0, pixel_on 0, busy 0, row buffer 16'hFFFF, latched parameters 0.
REQ-033 Assertion of rst_n during ISSUE or CAPTURE SHALL discard the fetch; the first line_start after release SHALL behave as REQ-022 or REQ-025.

Verification
REQ-034 pos(100,50), action 0, phase 0, scale 0, mirror 0, line_start with y=50 -> rom_addr=10'o0000, busy high 2 cycles, row buffer 16'hFC3F; pixel_on=1 one cycle after x=106..109 only.
REQ-035 Same parameters, y=54 -> rom_addr=10'o0400, row buffer 16'hF9DF; pixel_on only for x=105, 106, 110; with mirror=1, only for x=105, 109, 110.
REQ-036 scale=1, pos(100,50), y=59 -> row 4, rom_addr=10'o0400; pixel_on only for x=110..113 and 120..121.
REQ-037 action 4, phase 3, y=pos_y -> rom_addr=10'o0043, data 16'hFF0F; pixel_on only for columns 8..11; action 6 latched -> rom_addr frame bits equal 6'o03.
REQ-038 pos_x=630, scale=1 -> pixel_on for x=630..639 only, never at x=0..21; y=pos_y+32 -> no fetch, busy stays 0, pixel_on 0.
REQ-039 rst_n low during CAPTURE -> busy=0, pixel_on=0, row buffer 16'hFFFF; a second line_start during ISSUE -> rom_addr carries the new row and only the new data is loaded.
